lsr_seq: RTL and testbench

- Iterative right-shift unit; the right-direction companion to the single-cycle left shifter in the RISC5 CPU datapath.
- Performs logical shift right, arithmetic shift right and, optionally, rotate right on a 32-bit operand.
- Executes over several cycles: each cycle shifts by the largest of 16, 4 or 1 that does not exceed the remaining count.
- Used by the CPU control for LSR/ASR/ROR instructions, with a start/busy/done handshake to the stall logic.

---
 rtl/lsr_seq.sv | 68 ++++++
 tb/tb_lsr_seq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/lsr_seq.sv
// lsr_seq: iterative 32-bit shift right (LSR/ASR) in steps of 16, 4 or 1 per cycle.
// Define LSR_SEQ_ROR_EN to make mode 10 rotate right instead of shifting in zeros.
module lsr_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] value,
    input  logic [4:0]  shcnt,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] res
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state, state_n;
    logic [31:0] data, data_n, res_n, fill;
    logic [4:0]  cnt, cnt_n, step;
    logic [1:0]  md, md_n;
    logic        done_n;
`ifdef LSR_SEQ_ROR_EN
    assign fill = (md == 2'b10) ? data : {32{md == 2'b01 && data[31]}};
`else
    assign fill = {32{md == 2'b01 && data[31]}};
`endif
    assign busy = state == RUN;
    assign step = cnt[4] ? 5'd16 : |cnt[3:2] ? 5'd4 : 5'd1;
    always_comb begin
        state_n = state;
        data_n  = data;
        cnt_n   = cnt;
        md_n    = md;
        res_n   = res;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                state_n = RUN;
                data_n  = value;
                cnt_n   = shcnt;
                md_n    = mode;
            end
        end else if (cnt == 5'd0) begin
            res_n   = data;
            done_n  = 1'b1;
            state_n = IDLE;
        end else begin
            data_n = cnt[4] ? {fill[15:0], data[31:16]} :
                     |cnt[3:2] ? {fill[3:0], data[31:4]} : {fill[0], data[31:1]};
            cnt_n  = cnt - step;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            data  <= '0;
            cnt   <= '0;
            md    <= '0;
            res   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            data  <= data_n;
            cnt   <= cnt_n;
            md    <= md_n;
            res   <= res_n;
            done  <= done_n;
        end
    end
endmodule

// File: tb/tb_lsr_seq.sv
// tb_lsr_seq: directed self-checking bench for lsr_seq.
module tb_lsr_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value = '0;
    logic [4:0]  shcnt = '0;
    logic [1:0]  mode = '0;
    logic        busy, done;
    logic [31:0] res;
    int          passed = 0;
    int          total = 0;
    int          n, bc;

    lsr_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .value(value), .shcnt(shcnt),
                 .mode(mode), .busy(busy), .done(done), .res(res));

    always #5 clk = ~clk;

    task automatic launch(input logic [31:0] v, input logic [4:0] s, input logic [1:0] m);
        @(negedge clk);
        start = 1'b1; value = v; shcnt = s; mode = m;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = busy ? 1 : 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset;
        #3;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if (res !== 32'h0) $display("FAIL reset_res got %h want 00000000", res); else passed++;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_lsr;
        launch(32'h8000_0000, 5'd31, 2'b00);
        wait_done(n, bc);
        total++; if (n != 8) $display("FAIL lsr31_latency got %0d want 8", n); else passed++;
        total++; if (bc != 8) $display("FAIL lsr31_busy_cycles got %0d want 8", bc); else passed++;
        total++; if (res !== 32'h1) $display("FAIL lsr31_res got %h want 00000001", res); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL lsr31_busy_at_done got %b want 0", busy); else passed++;
        @(posedge clk); #1;
        total++; if (done !== 1'b0) $display("FAIL lsr31_done_pulse got %b want 0", done); else passed++;
    endtask

    task automatic test_asr;
        launch(32'h8000_0000, 5'd31, 2'b01);
        wait_done(n, bc);
        total++; if (res !== 32'hFFFF_FFFF) $display("FAIL asr31_res got %h want ffffffff", res); else passed++;
        launch(32'h7FFF_FFF0, 5'd4, 2'b01);
        wait_done(n, bc);
        total++; if (n != 2) $display("FAIL asr4_latency got %0d want 2", n); else passed++;
        total++; if (res !== 32'h07FF_FFFF) $display("FAIL asr4_res got %h want 07ffffff", res); else passed++;
    endtask

    task automatic test_ror;
        logic [31:0] exp;
`ifdef LSR_SEQ_ROR_EN
        exp = 32'h7812_3456;
`else
        exp = 32'h0012_3456;
`endif
        launch(32'h1234_5678, 5'd8, 2'b10);
        wait_done(n, bc);
        total++; if (n != 3) $display("FAIL ror8_latency got %0d want 3", n); else passed++;
        total++; if (res !== exp) $display("FAIL ror8_res got %h want %h", res, exp); else passed++;
    endtask

    task automatic test_zero;
        launch(32'hDEAD_BEEF, 5'd0, 2'b00);
        wait_done(n, bc);
        total++; if (n != 1) $display("FAIL zero_latency got %0d want 1", n); else passed++;
        total++; if (res !== 32'hDEAD_BEEF) $display("FAIL zero_res got %h want deadbeef", res); else passed++;
    endtask

    task automatic test_back_to_back;
        launch(32'h8000_0000, 5'd31, 2'b00);
        @(negedge clk);
        start = 1'b1; value = 32'hFFFF_FFFF; shcnt = 5'd0; mode = 2'b00;
        @(posedge clk);
        #1 start = 1'b0;
        total++; if (res !== 32'hDEAD_BEEF) $display("FAIL b2b_res_stable got %h want deadbeef", res); else passed++;
        wait_done(n, bc);
        total++; if (n != 7) $display("FAIL b2b_ignored_latency got %0d want 7", n); else passed++;
        total++; if (res !== 32'h1) $display("FAIL b2b_first_res got %h want 00000001", res); else passed++;
        start = 1'b1; value = 32'h0000_0100; shcnt = 5'd8; mode = 2'b00;
        @(posedge clk);
        #1 start = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL b2b_accept_busy got %b want 1", busy); else passed++;
        wait_done(n, bc);
        total++; if (n != 3) $display("FAIL b2b_second_latency got %0d want 3", n); else passed++;
        total++; if (res !== 32'h1) $display("FAIL b2b_second_res got %h want 00000001", res); else passed++;
    endtask

    task automatic test_reset_mid_run;
        int seen;
        launch(32'h8000_0000, 5'd31, 2'b01);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL midrst_done got %b want 0", done); else passed++;
        total++; if (res !== 32'h0) $display("FAIL midrst_res got %h want 00000000", res); else passed++;
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        total++; if (seen != 0) $display("FAIL midrst_no_done got %0d active cycles want 0", seen); else passed++;
    endtask

    initial begin
        test_reset;
        test_lsr;
        test_asr;
        test_ror;
        test_zero;
        test_back_to_back;
        test_reset_mid_run;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
